mac_psum_accumulator_mc: RTL and testbench

Multi-channel partial-sum accumulator placed after the MAC array reduction tree. It keeps NUM_CH independent accumulators and adds incoming 32-bit psums into the channel selected by an internal round-robin pointer. On the final pass it adds a per-channel bias, optionally applies ReLU, saturates, and queues the result in an output FIFO. The downstream requests results through a request/grant handshake. Successor to the single-channel accumulator, generalised in channel count, accumulator width, output buffering and mode.

---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_psum_fifo.sv | 76 +++++++
 rtl/mac_psum_accumulator_mc.sv | 121 ++++++++++++
 tb/tb_mac_psum_accumulator_mc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths and arithmetic helpers for the multi-channel psum accumulator.
// Helpers work on a wide signed type so callers can sign-extend into it.
package mac_pkg;

  localparam int unsigned DefPsumW = 32;
  localparam int unsigned DefAccW  = 40;
  localparam int unsigned DefOutW  = 32;
  localparam int unsigned CalcW    = 64;

  typedef logic signed [CalcW-1:0] calc_t;

  // Clamp to the signed range of an out_w-bit value.
  function automatic calc_t sat_signed(input calc_t value, input int unsigned out_w);
    calc_t max_v;
    calc_t min_v;
    max_v = (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    min_v = -max_v - calc_t'(1);
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

  function automatic calc_t relu(input calc_t value);
    return value[CalcW-1] ? '0 : value;
  endfunction

endpackage

// File: rtl/mac_psum_fifo.sv
// Synchronous FIFO whose read data is a registered copy of the head entry.
// The head register holds its last value once the FIFO drains.
module mac_psum_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = rdata_q;

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    rdata_d = rdata_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // The head register must track the entry that becomes the head after this edge.
    if (do_pop) begin
      if (count_q > CntW'(1)) begin
        rdata_d = mem_q[rptr_d];
      end else if (do_push) begin
        rdata_d = wdata_i;
      end
    end else if (do_push && empty_o) begin
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/mac_psum_accumulator_mc.sv
// Multi-channel psum accumulator: round-robin channel accumulation, bias/ReLU/saturate on the
// final pass, results buffered in an output FIFO for a request/grant downstream.
module mac_psum_accumulator_mc
  import mac_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PSUM_W     = DefPsumW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned OUT_W      = DefOutW,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          SAT_EN     = 1'b1,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              mac_psum_accumulator_mc_i_clk,
  input  logic              mac_psum_accumulator_mc_i_reset_n,
  input  logic              mac_psum_accumulator_mc_i_relu_en,
  output logic              mac_psum_accumulator_mc_o_psum_ready,
  input  logic              mac_psum_accumulator_mc_i_psum_valid,
  input  logic [PSUM_W-1:0] mac_psum_accumulator_mc_i_psum_data,
  input  logic              mac_psum_accumulator_mc_i_inter_end,
  input  logic              mac_psum_accumulator_mc_i_accum_end,
  output logic              mac_psum_accumulator_mc_o_bias_ready,
  input  logic              mac_psum_accumulator_mc_i_bias_valid,
  input  logic [PSUM_W-1:0] mac_psum_accumulator_mc_i_bias_data,
  output logic              mac_psum_accumulator_mc_o_output_ready,
  input  logic              mac_psum_accumulator_mc_i_output_valid,
  output logic [OUT_W-1:0]  mac_psum_accumulator_mc_o_output_data,
  output logic [CH_W-1:0]   mac_psum_accumulator_mc_o_ch_ptr
);

  localparam int unsigned SumW = ACC_W + 2;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  logic [ACC_W-1:0]    acc_q [NUM_CH];
  logic [ACC_W-1:0]    acc_d [NUM_CH];
  logic [CH_W-1:0]     ch_ptr_q, ch_ptr_d;
  logic [ACC_W-1:0]    acc_cur, acc_sum, psum_ext;
  logic [SumW-1:0]     fin_sum;
  calc_t               fin_ext, relu_val, sat_val;
  logic [OUT_W-1:0]    result;
  logic                fin, accept, psum_ready;
  logic                fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_count;
  logic                unused_bits;

  always_comb begin
    fin = mac_psum_accumulator_mc_i_psum_valid & mac_psum_accumulator_mc_i_inter_end &
          mac_psum_accumulator_mc_i_accum_end;
    // A final beat needs its bias and a free FIFO slot; a same-cycle pop does not help.
    psum_ready = fin ? (mac_psum_accumulator_mc_i_bias_valid & ~fifo_full) : 1'b1;
    accept     = mac_psum_accumulator_mc_i_psum_valid & psum_ready;

    acc_cur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ptr_q == CH_W'(i)) begin
        acc_cur = acc_q[i];
      end
    end

    psum_ext = {{(ACC_W - PSUM_W){mac_psum_accumulator_mc_i_psum_data[PSUM_W-1]}},
                mac_psum_accumulator_mc_i_psum_data};
    acc_sum  = acc_cur + psum_ext;
    fin_sum  = {{2{acc_cur[ACC_W-1]}}, acc_cur} +
               {{(SumW - PSUM_W){mac_psum_accumulator_mc_i_psum_data[PSUM_W-1]}},
                mac_psum_accumulator_mc_i_psum_data} +
               {{(SumW - PSUM_W){mac_psum_accumulator_mc_i_bias_data[PSUM_W-1]}},
                mac_psum_accumulator_mc_i_bias_data};
    fin_ext  = {{(CalcW - SumW){fin_sum[SumW-1]}}, fin_sum};
    relu_val = mac_psum_accumulator_mc_i_relu_en ? relu(fin_ext) : fin_ext;
    sat_val  = sat_signed(relu_val, OUT_W);
    result   = SAT_EN ? sat_val[OUT_W-1:0] : relu_val[OUT_W-1:0];

    acc_d = acc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && ch_ptr_q == CH_W'(i)) begin
        acc_d[i] = fin ? '0 : acc_sum;
      end
    end

    ch_ptr_d = ch_ptr_q;
    if (accept && mac_psum_accumulator_mc_i_inter_end) begin
      ch_ptr_d = (ch_ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ch_ptr_q + CH_W'(1);
    end
  end

  always_ff @(posedge mac_psum_accumulator_mc_i_clk or negedge mac_psum_accumulator_mc_i_reset_n)
  begin
    if (!mac_psum_accumulator_mc_i_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      ch_ptr_q <= '0;
    end else begin
      acc_q    <= acc_d;
      ch_ptr_q <= ch_ptr_d;
    end
  end

  mac_psum_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (mac_psum_accumulator_mc_i_clk),
    .rst_ni  (mac_psum_accumulator_mc_i_reset_n),
    .push_i  (accept & fin),
    .wdata_i (result),
    .pop_i   (mac_psum_accumulator_mc_i_output_valid),
    .rdata_o (mac_psum_accumulator_mc_o_output_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mac_psum_accumulator_mc_o_psum_ready   = psum_ready;
  assign mac_psum_accumulator_mc_o_bias_ready   = fin & psum_ready;
  assign mac_psum_accumulator_mc_o_output_ready = ~fifo_empty;
  assign mac_psum_accumulator_mc_o_ch_ptr       = ch_ptr_q;

  assign unused_bits = ^{sat_val[CalcW-1:OUT_W], relu_val[CalcW-1:OUT_W], fifo_count};

endmodule

// File: tb/tb_mac_psum_accumulator_mc.sv
// Scoreboard bench: instance A (4 ch, depth 2, saturating), instance B (1 ch, depth 4, wrapping).
module tb_mac_psum_accumulator_mc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       psum_valid, inter_end, accum_end, bias_valid, out_valid, relu_en;
  logic [1:0][31:0] psum_data, bias_data;
  logic [1:0]       psum_ready, bias_ready, out_ready;
  logic [1:0][31:0] out_data;
  logic [1:0]       ptr_a;
  logic [0:0]       ptr_b;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] exp0_v, exp1_v;

  mac_psum_accumulator_mc #(
    .NUM_CH(4), .PSUM_W(32), .ACC_W(40), .OUT_W(32), .FIFO_DEPTH(2), .SAT_EN(1'b1)
  ) dut_a (
    .mac_psum_accumulator_mc_i_clk          (clk),
    .mac_psum_accumulator_mc_i_reset_n      (rst_n),
    .mac_psum_accumulator_mc_i_relu_en      (relu_en[0]),
    .mac_psum_accumulator_mc_o_psum_ready   (psum_ready[0]),
    .mac_psum_accumulator_mc_i_psum_valid   (psum_valid[0]),
    .mac_psum_accumulator_mc_i_psum_data    (psum_data[0]),
    .mac_psum_accumulator_mc_i_inter_end    (inter_end[0]),
    .mac_psum_accumulator_mc_i_accum_end    (accum_end[0]),
    .mac_psum_accumulator_mc_o_bias_ready   (bias_ready[0]),
    .mac_psum_accumulator_mc_i_bias_valid   (bias_valid[0]),
    .mac_psum_accumulator_mc_i_bias_data    (bias_data[0]),
    .mac_psum_accumulator_mc_o_output_ready (out_ready[0]),
    .mac_psum_accumulator_mc_i_output_valid (out_valid[0]),
    .mac_psum_accumulator_mc_o_output_data  (out_data[0]),
    .mac_psum_accumulator_mc_o_ch_ptr       (ptr_a)
  );

  mac_psum_accumulator_mc #(
    .NUM_CH(1), .PSUM_W(32), .ACC_W(40), .OUT_W(32), .FIFO_DEPTH(4), .SAT_EN(1'b0)
  ) dut_b (
    .mac_psum_accumulator_mc_i_clk          (clk),
    .mac_psum_accumulator_mc_i_reset_n      (rst_n),
    .mac_psum_accumulator_mc_i_relu_en      (relu_en[1]),
    .mac_psum_accumulator_mc_o_psum_ready   (psum_ready[1]),
    .mac_psum_accumulator_mc_i_psum_valid   (psum_valid[1]),
    .mac_psum_accumulator_mc_i_psum_data    (psum_data[1]),
    .mac_psum_accumulator_mc_i_inter_end    (inter_end[1]),
    .mac_psum_accumulator_mc_i_accum_end    (accum_end[1]),
    .mac_psum_accumulator_mc_o_bias_ready   (bias_ready[1]),
    .mac_psum_accumulator_mc_i_bias_valid   (bias_valid[1]),
    .mac_psum_accumulator_mc_i_bias_data    (bias_data[1]),
    .mac_psum_accumulator_mc_o_output_ready (out_ready[1]),
    .mac_psum_accumulator_mc_i_output_valid (out_valid[1]),
    .mac_psum_accumulator_mc_o_output_data  (out_data[1]),
    .mac_psum_accumulator_mc_o_ch_ptr       (ptr_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: compare the FIFO head whenever the downstream takes it.
  always @(negedge clk) begin
    if (out_ready[0] && out_valid[0]) begin
      if (exp_q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_a_unexpected: got %h, expected no output", out_data[0]);
      end else begin
        exp0_v = exp_q0.pop_front();
        chk("out_a", out_data[0], exp0_v);
      end
    end
  end

  always @(negedge clk) begin
    if (out_ready[1] && out_valid[1]) begin
      if (exp_q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_b_unexpected: got %h, expected no output", out_data[1]);
      end else begin
        exp1_v = exp_q1.pop_front();
        chk("out_b", out_data[1], exp1_v);
      end
    end
  end

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic wait_accept(input int k);
    int n = 0;
    @(negedge clk);
    while (!psum_ready[k] && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!psum_ready[k]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: instance %0d got psum_ready 0, expected 1", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [31:0] p, input logic ie, input logic ae,
                      input logic bv, input logic [31:0] b);
    psum_valid[k] = 1'b1;
    psum_data[k]  = p;
    inter_end[k]  = ie;
    accum_end[k]  = ae;
    bias_valid[k] = bv;
    bias_data[k]  = b;
    wait_accept(k);
    psum_valid[k] = 1'b0;
    inter_end[k]  = 1'b0;
    accum_end[k]  = 1'b0;
    bias_valid[k] = 1'b0;
  endtask

  task automatic fin(input int k, input logic [31:0] p, input logic [31:0] b,
                     input logic [31:0] exp);
    if (k == 0) exp_q0.push_back(exp);
    else exp_q1.push_back(exp);
    send(k, p, 1'b1, 1'b1, 1'b1, b);
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (qsize(k) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (qsize(k) != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: instance %0d got %0d pending, expected 0", k, qsize(k));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    psum_valid = '0; inter_end = '0; accum_end = '0; bias_valid = '0;
    psum_data = '0; bias_data = '0; relu_en = '0; out_valid = 2'b11;
    #12;
    chk("rst_out_ready", 32'(out_ready[0]), 32'd0);
    chk("rst_out_data", out_data[0], 32'd0);
    chk("rst_psum_ready", 32'(psum_ready[0]), 32'd1);
    chk("rst_bias_ready", 32'(bias_ready[0]), 32'd0);
    chk("rst_ptr_a", 32'(ptr_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single channel, wrapping instance.
    send(1, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("b_ptr_wrap", 32'(ptr_b), 32'd0);
    send(1, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0);
    fin(1, 32'd3, 32'd10, 32'd25);
    fin(1, 32'd0, 32'd0, 32'd0);
    send(1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd0);
    fin(1, 32'd100, 32'd0, 32'h8000_0063);
    drain(1);
    chk("b_ptr_end", 32'(ptr_b), 32'd0);

    // Four channels: one pass then a final pass with biases.
    for (int i = 1; i <= 4; i++) send(0, 32'(i), 1'b1, 1'b0, 1'b0, 32'd0);
    fin(0, 32'd10, 32'd0, 32'd11);
    fin(0, 32'd20, 32'd0, 32'd22);
    fin(0, 32'd30, 32'd0, 32'd33);
    fin(0, 32'd40, -32'sd100, -32'sd56);
    chk("a_ptr_wrap", 32'(ptr_a), 32'd0);

    // Saturation on ch0, ReLU on ch1/ch2, accum_end without inter_end on ch3.
    send(0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    fin(0, 32'd100, 32'd0, 32'h7FFF_FFFF);
    relu_en[0] = 1'b1;
    fin(0, -32'sd8, 32'd0, 32'd0);
    relu_en[0] = 1'b0;
    fin(0, -32'sd10, 32'd2, 32'hFFFF_FFF8);
    send(0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("a_ptr_accum_only", 32'(ptr_a), 32'd3);
    fin(0, 32'd1, 32'd1, 32'd7);
    drain(0);
    chk("a_ptr_after_relu", 32'(ptr_a), 32'd0);

    // Backpressure with a full depth-2 FIFO.
    out_valid[0] = 1'b0;
    fin(0, 32'd1, 32'd0, 32'd1);
    fin(0, 32'd2, 32'd0, 32'd2);
    exp_q0.push_back(32'd3);
    psum_valid[0] = 1'b1; psum_data[0] = 32'd3; inter_end[0] = 1'b1; accum_end[0] = 1'b1;
    bias_valid[0] = 1'b1; bias_data[0] = 32'd0;
    repeat (2) @(negedge clk);
    chk("full_psum_ready", 32'(psum_ready[0]), 32'd0);
    chk("full_bias_ready", 32'(bias_ready[0]), 32'd0);
    chk("full_ptr", 32'(ptr_a), 32'd2);
    @(posedge clk);
    #1;
    out_valid[0] = 1'b1;
    @(negedge clk);
    chk("no_bypass_ready", 32'(psum_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    out_valid[0] = 1'b0;
    @(negedge clk);
    chk("after_pop_psum_ready", 32'(psum_ready[0]), 32'd1);
    chk("after_pop_bias_ready", 32'(bias_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    psum_valid[0] = 1'b0; inter_end[0] = 1'b0; accum_end[0] = 1'b0; bias_valid[0] = 1'b0;
    chk("after_accept_ptr", 32'(ptr_a), 32'd3);
    out_valid[0] = 1'b1;
    drain(0);

    // Final beat held without its bias.
    psum_valid[0] = 1'b1; psum_data[0] = 32'd4; inter_end[0] = 1'b1; accum_end[0] = 1'b1;
    bias_valid[0] = 1'b0; bias_data[0] = 32'd6;
    repeat (3) @(negedge clk);
    chk("nobias_psum_ready", 32'(psum_ready[0]), 32'd0);
    chk("nobias_bias_ready", 32'(bias_ready[0]), 32'd0);
    chk("nobias_ptr", 32'(ptr_a), 32'd3);
    @(posedge clk);
    #1;
    exp_q0.push_back(32'd10);
    bias_valid[0] = 1'b1;
    wait_accept(0);
    psum_valid[0] = 1'b0; inter_end[0] = 1'b0; accum_end[0] = 1'b0; bias_valid[0] = 1'b0;
    drain(0);
    chk("nobias_ptr_end", 32'(ptr_a), 32'd0);

    // Asynchronous reset with two results queued and a partial sum on ch2.
    out_valid[0] = 1'b0;
    fin(0, 32'd1, 32'd0, 32'd1);
    fin(0, 32'd2, 32'd0, 32'd2);
    send(0, 32'd50, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("pre_reset_out_ready", 32'(out_ready[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_ready", 32'(out_ready[0]), 32'd0);
    chk("mid_reset_out_data", out_data[0], 32'd0);
    chk("mid_reset_ptr", 32'(ptr_a), 32'd0);
    exp_q0.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_valid[0] = 1'b1;
    send(0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    send(0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    fin(0, 32'd9, 32'd1, 32'd10);
    drain(0);
    chk("post_reset_ptr", 32'(ptr_a), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
